// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word-aligned requests to instruction memory and
// presents fetched instructions (PC + instruction + valid) to the IF/ID register.
//
// Ports:
//   CLK, RESET        clock (rising edge), asynchronous active-low reset
//   STALL             IF/ID cannot accept; presented outputs hold
//   REDIRECT          taken branch/jump; flush and restart at REDIRECT_PC
//   REDIRECT_PC       redirect target (low two bits ignored)
//   IMEM_REQ/ADDR     memory request and word-aligned address (held until ACK)
//   IMEM_ACK/RDATA    request completes this cycle with instruction data
//   PC_o/Instr_o      presented PC and instruction
//   Valid_o           PC_o/Instr_o carry a real instruction (else Instr_o is a bubble)
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        STALL,
   input  logic        REDIRECT,
   input  logic [31:0] REDIRECT_PC,
   output logic        IMEM_REQ,
   output logic [31:0] IMEM_ADDR,
   input  logic        IMEM_ACK,
   input  logic [31:0] IMEM_RDATA,
   output logic [31:0] PC_o,
   output logic [31:0] Instr_o,
   output logic        Valid_o
);

   typedef enum logic [1:0] {StFetch, StHold, StDrop} state_e;

   state_e      state_q, state_d;
   logic        req_q, req_d;
   logic [31:0] req_addr_q, req_addr_d;
   logic [31:0] next_pc_q, next_pc_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic [31:0] skid_instr_q, skid_instr_d;

   logic        ack;
   logic [31:0] redir_pc;
   logic        unused_redir_lsb;

   // An ACK with no request outstanding is stray and must not be consumed.
   assign ack              = IMEM_ACK & req_q;
   assign redir_pc         = {REDIRECT_PC[31:2], 2'b00};
   assign unused_redir_lsb = ^REDIRECT_PC[1:0];

   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      req_addr_d   = req_addr_q;
      next_pc_d    = next_pc_q;
      pc_d         = pc_q;
      instr_d      = instr_q;
      valid_d      = valid_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;

      unique case (state_q)
         StFetch: begin
            if (REDIRECT) begin
               valid_d   = 1'b0;
               instr_d   = NOP_INSTR;
               next_pc_d = redir_pc;
               if (req_q && !ack) begin
                  // Outstanding request must still complete; its data is thrown away.
                  state_d = StDrop;
               end else begin
                  req_d      = 1'b1;
                  req_addr_d = redir_pc;
               end
            end else if (!req_q) begin
               // Only reachable right after reset: launch the first request.
               req_d      = 1'b1;
               req_addr_d = next_pc_q;
               if (!STALL) begin
                  valid_d = 1'b0;
                  instr_d = NOP_INSTR;
               end
            end else if (ack) begin
               next_pc_d = req_addr_q + 32'd4;
               if (STALL) begin
                  skid_pc_d    = req_addr_q;
                  skid_instr_d = IMEM_RDATA;
                  req_d        = 1'b0;
                  state_d      = StHold;
               end else begin
                  pc_d       = req_addr_q;
                  instr_d    = IMEM_RDATA;
                  valid_d    = 1'b1;
                  req_addr_d = req_addr_q + 32'd4;
               end
            end else if (!STALL) begin
               valid_d = 1'b0;
               instr_d = NOP_INSTR;
            end
         end

         StHold: begin
            if (REDIRECT) begin
               valid_d      = 1'b0;
               instr_d      = NOP_INSTR;
               skid_pc_d    = '0;
               skid_instr_d = NOP_INSTR;
               next_pc_d    = redir_pc;
               req_addr_d   = redir_pc;
               req_d        = 1'b1;
               state_d      = StFetch;
            end else if (!STALL) begin
               pc_d       = skid_pc_q;
               instr_d    = skid_instr_q;
               valid_d    = 1'b1;
               next_pc_d  = skid_pc_q + 32'd4;
               req_addr_d = skid_pc_q + 32'd4;
               req_d      = 1'b1;
               state_d    = StFetch;
            end
         end

         StDrop: begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            if (REDIRECT) begin
               next_pc_d = redir_pc;
            end
            if (ack) begin
               req_addr_d = REDIRECT ? redir_pc : next_pc_q;
               req_d      = 1'b1;
               state_d    = StFetch;
            end
         end

         default: begin
            state_d = StFetch;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q      <= StFetch;
         req_q        <= 1'b0;
         req_addr_q   <= RESET_PC;
         next_pc_q    <= RESET_PC;
         pc_q         <= '0;
         instr_q      <= NOP_INSTR;
         valid_q      <= 1'b0;
         skid_pc_q    <= '0;
         skid_instr_q <= NOP_INSTR;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         req_addr_q   <= req_addr_d;
         next_pc_q    <= next_pc_d;
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         valid_q      <= valid_d;
         skid_pc_q    <= skid_pc_d;
         skid_instr_q <= skid_instr_d;
      end
   end

   assign IMEM_REQ  = req_q;
   assign IMEM_ADDR = req_addr_q;
   assign PC_o      = pc_q;
   assign Instr_o   = instr_q;
   assign Valid_o   = valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit. The reference model is the
// program-order stream of PCs the pipeline should accept: sequential words from the
// last redirect target (or reset PC), with memory returning addr ^ KEY.
module tb_instr_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_1000;
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] KEY    = 32'hA5A5_A5A5;

   logic        CLK;
   logic        RESET;
   logic        STALL;
   logic        REDIRECT;
   logic [31:0] REDIRECT_PC;
   logic        IMEM_REQ;
   logic [31:0] IMEM_ADDR;
   logic        IMEM_ACK;
   logic [31:0] IMEM_RDATA;
   logic [31:0] PC_o;
   logic [31:0] Instr_o;
   logic        Valid_o;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] exp_q[$];

   instr_fetch_unit #(
      .RESET_PC  (RST_PC),
      .NOP_INSTR (NOP)
   ) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .STALL       (STALL),
      .REDIRECT    (REDIRECT),
      .REDIRECT_PC (REDIRECT_PC),
      .IMEM_REQ    (IMEM_REQ),
      .IMEM_ADDR   (IMEM_ADDR),
      .IMEM_ACK    (IMEM_ACK),
      .IMEM_RDATA  (IMEM_RDATA),
      .PC_o        (PC_o),
      .Instr_o     (Instr_o),
      .Valid_o     (Valid_o)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Memory model: every word holds its own address XOR KEY.
   assign IMEM_RDATA = IMEM_ADDR ^ KEY;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic push_seg(input logic [31:0] start, input int n);
      for (int k = 0; k < n; k++) exp_q.push_back(start + 32'(4 * k));
   endtask

   // Monitor: invariants every cycle plus in-order scoreboard on each accepted instruction.
   logic        prev_pend = 1'b0;
   logic [31:0] prev_addr = '0;
   logic [31:0] e;
   always @(negedge CLK) begin
      if (!RESET) begin
         prev_pend = 1'b0;
      end else begin
         if (prev_pend) begin
            check32("req_stable", 32'(IMEM_REQ), 32'd1);
            check32("addr_stable", IMEM_ADDR, prev_addr);
         end
         check32("addr_align", 32'(IMEM_ADDR[1:0]), 32'd0);
         if (!Valid_o) check32("bubble_instr", Instr_o, NOP);
         if (Valid_o && !STALL && !REDIRECT) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_instr: got pc %h, expected no instruction", PC_o);
            end else begin
               e = exp_q.pop_front();
               check32("pc", PC_o, e);
               check32("instr", Instr_o, e ^ KEY);
            end
         end
         prev_pend = IMEM_REQ && !IMEM_ACK;
         prev_addr = IMEM_ADDR;
      end
   end

   // Random traffic in segments; each segment ends with a redirect once its expected
   // instructions have all been accepted. Entered and left at posedge+1.
   task automatic run_random(input logic [31:0] start, input int n_seg);
      int          remaining;
      int          seg;
      int          cyc;
      bit          dbl;
      logic [31:0] t;
      remaining = $urandom_range(4, 8);
      push_seg(start, remaining);
      seg = 0;
      cyc = 0;
      dbl = 1'b0;
      while (!(seg >= n_seg && remaining == 0)) begin
         if (cyc > 5000) begin
            n_checks++;
            $display("FAIL timeout: got %0d instructions outstanding, expected 0", remaining);
            break;
         end
         if (remaining == 0) begin
            REDIRECT = 1'b1;
            STALL    = 1'($urandom % 2);
            IMEM_ACK = 1'($urandom % 2);
            if (!dbl && ($urandom % 4) == 0) begin
               // Throw-away redirect, overridden by the next one.
               REDIRECT_PC = $urandom;
               dbl         = 1'b1;
            end else begin
               seg++;
               case (seg % 4)
                  1:       t = 32'hFFFF_FFF6;
                  2:       t = 32'h0000_0203;
                  default: t = $urandom;
               endcase
               REDIRECT_PC = t;
               dbl         = 1'b0;
               remaining   = $urandom_range(4, 8);
               push_seg({t[31:2], 2'b00}, remaining);
            end
         end else begin
            REDIRECT = 1'b0;
            if (seg == 0) begin
               STALL    = 1'b0;
               IMEM_ACK = 1'b1;
            end else begin
               STALL    = ($urandom % 10) < 3;
               IMEM_ACK = ($urandom % 10) < 6;
            end
            if (Valid_o && !STALL) remaining--;
         end
         @(posedge CLK);
         #1;
         cyc++;
      end
      // Squash whatever is in flight and park with a request pending, nothing valid.
      REDIRECT    = 1'b1;
      STALL       = 1'b1;
      IMEM_ACK    = 1'b0;
      REDIRECT_PC = $urandom;
      @(posedge CLK);
      #1;
      REDIRECT = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check32({tag, "_req"}, 32'(IMEM_REQ), 32'd0);
      check32({tag, "_addr"}, IMEM_ADDR, RST_PC);
      check32({tag, "_pc"}, PC_o, 32'd0);
      check32({tag, "_instr"}, Instr_o, NOP);
      check32({tag, "_valid"}, 32'(Valid_o), 32'd0);
   endtask

   task automatic release_reset();
      // Stray ACK while no request is outstanding must be ignored.
      IMEM_ACK = 1'b1;
      STALL    = 1'b0;
      REDIRECT = 1'b0;
      @(posedge CLK);
      @(posedge CLK);
      #3;
      RESET = 1'b1;
      @(posedge CLK);
      #1;
      check32("first_req", 32'(IMEM_REQ), 32'd1);
      check32("first_addr", IMEM_ADDR, RST_PC);
      check32("first_valid", 32'(Valid_o), 32'd0);
   endtask

   initial begin
      RESET       = 1'b1;
      STALL       = 1'b0;
      REDIRECT    = 1'b0;
      REDIRECT_PC = '0;
      IMEM_ACK    = 1'b0;
      #1;
      RESET = 1'b0;
      #1;
      check_reset_vals("reset");
      release_reset();
      run_random(RST_PC, 25);

      // Asynchronous reset while a request is waiting for its ACK.
      check32("req_before_reset", 32'(IMEM_REQ), 32'd1);
      #2;
      RESET = 1'b0;
      #1;
      check_reset_vals("async_reset");
      check32("queue_drained", 32'(exp_q.size()), 32'd0);
      release_reset();
      run_random(RST_PC, 12);

      repeat (3) @(posedge CLK);
      #1;
      check32("queue_final", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, is the bubble instruction (addi x0,x0,0).
REQ-003 CLK  input  1  clock; all state SHALL update on rising edge.
REQ-004 RESET  input  1  reset, asynchronous, active-low.
REQ-005 STALL  input  1  downstream (IF/ID) cannot accept; fetch packet outputs SHALL hold.
REQ-006 REDIRECT  input  1  branch/jump taken; flush and restart at REDIRECT_PC.
REQ-007 REDIRECT_PC  input  32  redirect target.
REQ-008 IMEM_REQ  output  1  instruction memory request.
REQ-009 IMEM_ADDR  output  32  word-aligned request address.
REQ-010 IMEM_ACK  input  1  request completes this cycle; IMEM_RDATA valid.
REQ-011 IMEM_RDATA  input  32  fetched instruction.
REQ-012 PC_o  output  32  PC of presented instruction, to IF/ID PC.
REQ-013 Instr_o  output  32  presented instruction, to IF/ID Instr.
REQ-014 Valid_o  output  1  PC_o/Instr_o carry a real instruction.

Function
REQ-015 States SHALL be FETCH, HOLD, DROP; reset state FETCH.
REQ-016 Two address registers: next_pc (next fetch) and req_addr (outstanding request); IMEM_ADDR SHALL equal req_addr.
REQ-017 Memory protocol: once IMEM_REQ=1, IMEM_REQ and IMEM_ADDR SHALL stay stable until the cycle IMEM_ACK=1; IMEM_ACK while IMEM_REQ=0 SHALL be ignored.
REQ-018 FETCH: IMEM_REQ=1; on ACK with STALL=0 and REDIRECT=0: PC_o<=req_addr, Instr_o<=IMEM_RDATA, Valid_o<=1, next request at req_addr+4 issued next cycle (zero-bubble back-to-back fetch).
REQ-019 FETCH, no ACK, STALL=0, REDIRECT=0: Valid_o<=0, Instr_o<=NOP_INSTR, PC_o unchanged.
REQ-020 FETCH, ACK with STALL=1, REDIRECT=0: instruction and address captured in one-entry skid buffer, outputs held, next state HOLD.
REQ-021 HOLD: IMEM_REQ=0; outputs held while STALL=1; when STALL=0, outputs<=buffer with Valid_o=1, request at buffered address+4, next state FETCH.
REQ-022 Any STALL=1 cycle without buffered data SHALL leave PC_o/Instr_o/Valid_o unchanged.
REQ-023 REDIRECT=1 SHALL take priority over STALL and ACK: Valid_o<=0, Instr_o<=NOP_INSTR, skid buffer cleared, next_pc<={REDIRECT_PC[31:2],2'b00}.
REQ-024 REDIRECT with request outstanding and no ACK that cycle: next state DROP; DROP holds IMEM_REQ/req_addr until ACK, discards RDATA, then issues request at next_pc in FETCH.
REQ-025 REDIRECT in DROP SHALL overwrite next_pc only; remain in DROP.
REQ-026 REDIRECT coincident with ACK, or in HOLD: data discarded, request at redirect target next cycle in FETCH.
REQ-027 Address increment SHALL be modulo 2^32 (32'hFFFF_FFFC+4 -> 32'h0000_0000); IMEM_ADDR[1:0] SHALL always be 2'b00.
REQ-028 Valid_o=0 SHALL always coincide with Instr_o=NOP_INSTR.

Reset
REQ-029 While RESET=0: IMEM_REQ=0, IMEM_ADDR=RESET_PC, PC_o=0, Instr_o=NOP_INSTR, Valid_o=0, buffer empty, state FETCH.
REQ-030 First rising edge after RESET deasserts SHALL raise IMEM_REQ with IMEM_ADDR=RESET_PC.
REQ-031 Reset asserted mid-request SHALL abandon the request immediately; late ACK after reset release, with no new request yet issued, is ignored.

Verification
REQ-032 Reset release, ACK every cycle, RDATA=addr^32'hA5A5_A5A5 -> Valid_o=1 each cycle, PC_o 0,4,8,... with matching Instr_o.
REQ-033 ACK at addr 0x10 while STALL=1 for 3 cycles -> IMEM_REQ=0 during stall, outputs frozen; STALL drop -> PC_o=0x10, then request 0x14.
REQ-034 REDIRECT to 0x203 while request 0x40 pending, ACK 2 cycles later -> 0x40 data never presented, next IMEM_ADDR=0x200, Valid_o=0 until 0x200 returns.
REQ-035 REDIRECT and ACK same cycle, STALL=1 -> Valid_o=0, Instr_o=0x0000_0013, next request at target.
REQ-036 Redirect to 0xFFFF_FFFC, ACK continuous -> IMEM_ADDR sequence 0xFFFF_FFFC, 0x0000_0000.
REQ-037 RESET asserted with IMEM_REQ=1 awaiting ACK -> outputs to reset values asynchronously; after release first IMEM_ADDR=RESET_PC.
